// File: rtl/lht_param.sv
// lht_param: local branch-history table, one shift-register history per
// entry, indexed by a PC slice, with a built-in clear sweep after reset/flush.
//
// Ports:
//   clock, reset (async, active-low)
//   lookup_valid/lookup_pc/lookup_ready : lookup request, accepted on valid&&ready
//   resp_valid/resp_idx/resp_hist       : response, one cycle after accept
//   upd_valid/upd_idx/upd_taken         : history update (shift in at MSB)
//   upd_drop                            : pulses one cycle after an update
//                                         that arrived during the clear sweep
//   flush                               : restart the clear sweep
//   init_done                           : table is cleared and in service
//
// Build option: LHT_BYPASS_EN forwards a same-cycle update to the lookup
// response; without it the response carries the pre-update history.

module lht_param #(
   parameter int ENTRIES = 1024,
   parameter int HIST_W  = 10,
   parameter int PC_LSB  = 2,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lookup_valid,
   input  logic [31:0]       lookup_pc,
   output logic              lookup_ready,
   output logic              resp_valid,
   output logic [IDX_W-1:0]  resp_idx,
   output logic [HIST_W-1:0] resp_hist,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   output logic              upd_drop,
   input  logic              flush,
   output logic              init_done
);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  w_cnt_nxt;

   logic [HIST_W-1:0] r_mem [ENTRIES];

   logic              w_run;
   logic              w_accept;
   logic              w_upd_en;
   logic [IDX_W-1:0]  w_lidx;
   logic [HIST_W-1:0] w_upd_old;
   logic [HIST_W-1:0] w_upd_new;
   logic [HIST_W-1:0] w_rd;
   logic              w_unused_pc;

   assign w_run     = (r_state == S_RUN);
   assign w_lidx    = lookup_pc[PC_LSB +: IDX_W];
   assign w_accept  = lookup_valid && w_run;
   assign w_upd_en  = upd_valid && w_run;
   assign w_upd_old = r_mem[upd_idx];
   assign w_upd_new = {upd_taken, w_upd_old[HIST_W-1:1]};

   // PC bits outside the index slice are intentionally ignored
   assign w_unused_pc = ^lookup_pc;

`ifdef LHT_BYPASS_EN
   logic w_hit;
   assign w_hit = w_upd_en && (upd_idx == w_lidx);
   assign w_rd  = w_hit ? w_upd_new : r_mem[w_lidx];
`else
   assign w_rd  = r_mem[w_lidx];
`endif

   assign lookup_ready = w_run;
   assign init_done    = w_run;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_INIT: begin
            if (r_cnt == IDX_W'(ENTRIES - 1)) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
            w_state_nxt = S_RUN;
         end
         default: begin
            w_state_nxt = S_INIT;
            w_cnt_nxt   = '0;
         end
      endcase
      // flush wins over sweep progress: restart from entry 0
      if (flush) begin
         w_state_nxt = S_INIT;
         w_cnt_nxt   = '0;
      end
   end

   // Table storage: sweep writes zeros, otherwise updates shift in at MSB
   always_ff @(posedge clock) begin
      if (r_state == S_INIT) begin
         r_mem[r_cnt] <= '0;
      end else if (upd_valid) begin
         r_mem[upd_idx] <= w_upd_new;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_valid <= 1'b0;
         resp_idx   <= '0;
         resp_hist  <= '0;
         upd_drop   <= 1'b0;
      end else begin
         resp_valid <= w_accept;
         upd_drop   <= upd_valid && !w_run;
         if (w_accept) begin
            resp_idx  <= w_lidx;
            resp_hist <= w_rd;
         end
      end
   end

endmodule
